instr_decode_stage: RTL and testbench
=====================================

# instr_decode_stage

Registered decode stage directly downstream of the instruction fetch unit. Each cycle it captures the fetched 32-bit instruction and its 30-bit word PC, decodes the MIPS subset into control flags and operand fields, and presents them one cycle later to the register file, ALU and the fetch unit's redirect inputs (Jump, JumpReg, Branch, InvZero, TargetInstr, imm16). A small FSM squashes the wrong-path slot after unconditional jumps and optionally traps on illegal opcodes.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_pc  in  30  word PC of in_instr
- in_instr  in  32  fetched instruction
- in_valid  in  1  in_instr/in_pc are meaningful this cycle
- stall  in  1  hold all outputs and state
- flush  in  1  discard the current capture; emit a bubble
- out_valid  out  1  decoded outputs are meaningful
- out_pc  out  30  registered in_pc
- Jump, JumpReg, Branch, InvZero  out  1 each  redirect flags to fetch
- TargetInstr  out  26  instr[25:0]
- imm16  out  16  instr[15:0]
- rs, rt  out  5 each  source register numbers
- dest_reg  out  5  write-back register
- RegWrite, MemWrite, MemToReg, ALUSrc  out  1 each  datapath controls
- ALUop  out  2  0 ADD, 1 SUB, 2 XOR, 3 SLT
- illegal  out  1  sticky illegal-opcode flag

## Operation
- Decoded opcodes:
  - LW 0x23: RegWrite, MemToReg, ALUSrc, ADD, dest=rt.
  - SW 0x2B: MemWrite, ALUSrc, ADD.
  - ADDI 0x08: RegWrite, ALUSrc, ADD, dest=rt.
  - XORI 0x0E: RegWrite, ALUSrc, XOR, dest=rt.
  - BEQ 0x04: Branch, SUB.
  - BNE 0x05: Branch, InvZero, SUB.
  - J 0x02: Jump.
  - JAL 0x03: Jump, RegWrite, dest=31.
- R-type (opcode 0x00), by funct:
  - ADD 0x20, SUB 0x22, SLT 0x2A: RegWrite, dest=rd.
  - JR 0x08: JumpReg only.
- Any other opcode/funct is illegal.
- Every flag not listed for an instruction is 0. Fields (rs, rt, TargetInstr, imm16) are raw bit slices.
- When out_valid=0, all flags (Jump, JumpReg, Branch, InvZero, RegWrite, MemWrite, MemToReg, ALUSrc) are forced to 0. Fields may hold stale values.
- FSM states:
  - RUN: capture when in_valid. If the decoded instruction is J/JAL/JR → SQUASH.
  - SQUASH: the next captured instruction is replaced by a bubble (out_valid=0); return to RUN.
  - HALT: out_valid=0 permanently; illegal=1; exit only via rst_n.
- Branches are not squashed: the fetch unit resolves them with the ALU Zero flag.
- Priority per edge: rst_n > HALT > flush > stall > capture.
  - flush: out_valid←0, state←RUN.
  - stall: all outputs and state unchanged, even if in_valid=1.
- A SQUASH slot is consumed only by an actual capture (in_valid=1 and not stalled). A bubble with in_valid=0 does not consume it.

## Timing
- Reset (async assert, sync-free deassert): state RUN, out_valid=0, illegal=0, out_pc=0, all flags/fields 0, ALUop=0.
- Latency: in_instr sampled at posedge N → outputs valid after posedge N, held until posedge N+1.
- Squash takes effect on the capture immediately following the jump's capture.
- flush asserted with an illegal in_instr: flush wins, no trap.
- Reset mid-SQUASH or mid-HALT returns to RUN with no pending squash.

## Configuration
- ID_ILLEGAL_TRAP_EN defined: illegal opcode → out_valid=0, illegal=1, state HALT.
- ID_ILLEGAL_TRAP_EN undefined:
  - Illegal opcode decodes as a NOP: out_valid=1, all flags 0.
  - illegal is tied to 0.
  - The HALT state is absent.

## Test plan
- ADD: 0x00221820 with in_valid=1 → next cycle out_valid=1, rs=1, rt=2, dest_reg=3, RegWrite=1, ALUop=0, all other flags 0.
- J then ADDI: 0x08000009 then 0x20010005 on consecutive cycles → first output Jump=1, TargetInstr=9. Second output out_valid=0. Third capture decodes normally.
- JAL: 0x0C000005 → Jump=1, RegWrite=1, dest_reg=31. Followed by JR 0x03E00008 (after the squash slot) → JumpReg=1, rs=31, RegWrite=0.
- BNE: 0x14220003 → Branch=1, InvZero=1, imm16=3, ALUop=1. Next instruction is not squashed.
- Stall and flush: assert stall for 3 cycles during a LW 0x8C230004 → outputs constant. flush → out_valid=0 next cycle. Repeat with J followed by flush → SQUASH cleared.
- Illegal 0xFC000000 with ID_ILLEGAL_TRAP_EN → illegal=1 and out_valid=0 until rst_n pulse. Without the macro → out_valid=1, flags 0, illegal=0.

Source files
------------

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered MIPS-subset decode between fetch and register file / ALU / redirect logic.
// Latency: one cycle. in_instr and in_pc sampled at posedge N are presented after posedge N.
// Backpressure: stall freezes every output and the FSM. flush emits a bubble and drops any pending squash.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_pc, in_instr         fetched word PC and instruction
//   in_valid                in_pc/in_instr are meaningful this cycle
//   stall, flush            hold everything / discard the current capture
//   out_valid, out_pc       decoded slot is meaningful, and its PC
//   Jump, JumpReg, Branch, InvZero   redirect flags to fetch
//   TargetInstr, imm16, rs, rt       raw instruction fields
//   dest_reg                write-back register
//   RegWrite, MemWrite, MemToReg, ALUSrc, ALUop   datapath controls
//   illegal                 sticky illegal-opcode flag
//
// Build option ID_ILLEGAL_TRAP_EN: when defined, an illegal instruction halts the
// stage (out_valid=0, illegal=1) until reset. When undefined, illegal instructions
// decode as a NOP and illegal is tied to 0.
module instr_decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] in_pc,
    input  logic [31:0] in_instr,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    output logic        out_valid,
    output logic [29:0] out_pc,
    output logic        Jump,
    output logic        JumpReg,
    output logic        Branch,
    output logic        InvZero,
    output logic [25:0] TargetInstr,
    output logic [15:0] imm16,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  dest_reg,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        MemToReg,
    output logic        ALUSrc,
    output logic [1:0]  ALUop,
    output logic        illegal
);

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_XOR = 2'd2;
    localparam logic [1:0] ALU_SLT = 2'd3;

    typedef struct packed {
        logic       jump;
        logic       jump_reg;
        logic       branch;
        logic       inv_zero;
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [1:0] alu_op;
        logic [4:0] dest;
    } ctl_t;

`ifdef ID_ILLEGAL_TRAP_EN
    typedef enum logic [1:0] {RUN = 2'd0, SQUASH = 2'd1, HALT = 2'd2} state_t;
`else
    typedef enum logic [0:0] {RUN = 1'b0, SQUASH = 1'b1} state_t;
`endif

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] f_rt;
    logic [4:0] f_rd;
    ctl_t       dec;
    logic       dec_redirect;   // unconditional jump: next capture is wrong-path
`ifdef ID_ILLEGAL_TRAP_EN
    logic       dec_bad;
`endif

    assign opcode = in_instr[31:26];
    assign funct  = in_instr[5:0];
    assign f_rt   = in_instr[20:16];
    assign f_rd   = in_instr[15:11];

    always_comb begin
        dec          = '0;
        dec_redirect = 1'b0;
`ifdef ID_ILLEGAL_TRAP_EN
        dec_bad      = 1'b0;
`endif
        case (opcode)
            6'h23: begin // LW
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_src    = 1'b1;
                dec.alu_op     = ALU_ADD;
                dec.dest       = f_rt;
            end
            6'h2B: begin // SW
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_ADD;
            end
            6'h08: begin // ADDI
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_ADD;
                dec.dest      = f_rt;
            end
            6'h0E: begin // XORI
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_XOR;
                dec.dest      = f_rt;
            end
            6'h04: begin // BEQ
                dec.branch = 1'b1;
                dec.alu_op = ALU_SUB;
            end
            6'h05: begin // BNE
                dec.branch   = 1'b1;
                dec.inv_zero = 1'b1;
                dec.alu_op   = ALU_SUB;
            end
            6'h02: begin // J
                dec.jump     = 1'b1;
                dec_redirect = 1'b1;
            end
            6'h03: begin // JAL
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec.dest      = 5'd31;
                dec_redirect  = 1'b1;
            end
            6'h00: begin // R-type
                case (funct)
                    6'h20: begin
                        dec.reg_write = 1'b1;
                        dec.alu_op    = ALU_ADD;
                        dec.dest      = f_rd;
                    end
                    6'h22: begin
                        dec.reg_write = 1'b1;
                        dec.alu_op    = ALU_SUB;
                        dec.dest      = f_rd;
                    end
                    6'h2A: begin
                        dec.reg_write = 1'b1;
                        dec.alu_op    = ALU_SLT;
                        dec.dest      = f_rd;
                    end
                    6'h08: begin // JR
                        dec.jump_reg = 1'b1;
                        dec_redirect = 1'b1;
                    end
                    default: begin
`ifdef ID_ILLEGAL_TRAP_EN
                        dec_bad = 1'b1;
`endif
                    end
                endcase
            end
            default: begin
`ifdef ID_ILLEGAL_TRAP_EN
                dec_bad = 1'b1;
`endif
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Slot-control FSM: next state, next out_valid, capture enable
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    logic   vld_q, vld_d;
    logic   capture;
`ifdef ID_ILLEGAL_TRAP_EN
    logic   ill_q, ill_d;
`endif

    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        capture = 1'b0;
`ifdef ID_ILLEGAL_TRAP_EN
        ill_d   = ill_q;
        if (state_q == HALT) begin
            vld_d = 1'b0;
        end else
`endif
        if (flush) begin
            vld_d   = 1'b0;
            state_d = RUN;
        end else if (stall) begin
            // everything holds
        end else if (!in_valid) begin
            // a bubble from fetch does not consume a pending squash
            vld_d = 1'b0;
        end else begin
            capture = 1'b1;
            if (state_q == SQUASH) begin
                // wrong-path slot after J/JAL/JR; dropped without trapping
                vld_d   = 1'b0;
                state_d = RUN;
            end
`ifdef ID_ILLEGAL_TRAP_EN
            else if (dec_bad) begin
                vld_d   = 1'b0;
                ill_d   = 1'b1;
                state_d = HALT;
            end
`endif
            else begin
                vld_d = 1'b1;
                if (dec_redirect) begin
                    state_d = SQUASH;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            vld_q   <= 1'b0;
`ifdef ID_ILLEGAL_TRAP_EN
            ill_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
`ifdef ID_ILLEGAL_TRAP_EN
            ill_q   <= ill_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Captured fields and controls
    // ------------------------------------------------------------------
    ctl_t        ctl_q;
    logic [29:0] pc_q;
    logic [25:0] tgt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q <= '0;
            pc_q  <= '0;
            tgt_q <= '0;
        end else if (capture) begin
            ctl_q <= dec;
            pc_q  <= in_pc;
            tgt_q <= in_instr[25:0];
        end
    end

    assign out_valid   = vld_q;
    assign out_pc      = pc_q;
    assign TargetInstr = tgt_q;
    assign imm16       = tgt_q[15:0];
    assign rs          = tgt_q[25:21];
    assign rt          = tgt_q[20:16];
    assign dest_reg    = ctl_q.dest;
    assign ALUop       = ctl_q.alu_op;

    // flags never leak out of a bubble
    assign Jump     = vld_q & ctl_q.jump;
    assign JumpReg  = vld_q & ctl_q.jump_reg;
    assign Branch   = vld_q & ctl_q.branch;
    assign InvZero  = vld_q & ctl_q.inv_zero;
    assign RegWrite = vld_q & ctl_q.reg_write;
    assign MemWrite = vld_q & ctl_q.mem_write;
    assign MemToReg = vld_q & ctl_q.mem_to_reg;
    assign ALUSrc   = vld_q & ctl_q.alu_src;

`ifdef ID_ILLEGAL_TRAP_EN
    assign illegal = ill_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage with hand-computed expected values.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] in_pc;
    logic [31:0] in_instr;
    logic        in_valid, stall, flush;
    logic        out_valid;
    logic [29:0] out_pc;
    logic        Jump, JumpReg, Branch, InvZero;
    logic [25:0] TargetInstr;
    logic [15:0] imm16;
    logic [4:0]  rs, rt, dest_reg;
    logic        RegWrite, MemWrite, MemToReg, ALUSrc;
    logic [1:0]  ALUop;
    logic        illegal;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [7:0] F_J   = 8'h80;
    localparam logic [7:0] F_JR  = 8'h40;
    localparam logic [7:0] F_BR  = 8'h20;
    localparam logic [7:0] F_INV = 8'h10;
    localparam logic [7:0] F_RW  = 8'h08;
    localparam logic [7:0] F_MW  = 8'h04;
    localparam logic [7:0] F_MR  = 8'h02;
    localparam logic [7:0] F_AS  = 8'h01;

    localparam logic [31:0] I_ADD  = 32'h0022_1820;
    localparam logic [31:0] I_SUB  = 32'h0022_1822;
    localparam logic [31:0] I_SLT  = 32'h0022_182A;
    localparam logic [31:0] I_J9   = 32'h0800_0009;
    localparam logic [31:0] I_ADDI = 32'h2001_0005;
    localparam logic [31:0] I_JAL  = 32'h0C00_0005;
    localparam logic [31:0] I_XORI = 32'h3822_0007;
    localparam logic [31:0] I_JR   = 32'h03E0_0008;
    localparam logic [31:0] I_BNE  = 32'h1422_0003;
    localparam logic [31:0] I_LW   = 32'h8C23_0004;
    localparam logic [31:0] I_SW   = 32'hAC23_0004;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;

    logic [7:0] flags;
    assign flags = {Jump, JumpReg, Branch, InvZero, RegWrite, MemWrite, MemToReg, ALUSrc};

    instr_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .in_pc(in_pc), .in_instr(in_instr),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_pc(out_pc),
        .Jump(Jump), .JumpReg(JumpReg), .Branch(Branch), .InvZero(InvZero),
        .TargetInstr(TargetInstr), .imm16(imm16), .rs(rs), .rt(rt),
        .dest_reg(dest_reg), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .ALUSrc(ALUSrc), .ALUop(ALUop), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // present one input slot, clock it, sample 1ns after the edge
    task automatic drive(input logic [29:0] pc, input logic [31:0] instr,
                         input logic vld, input logic stl, input logic fl);
        in_pc    = pc;
        in_instr = instr;
        in_valid = vld;
        stall    = stl;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic vld, input logic [7:0] f,
                              input logic [1:0] aop, input logic [4:0] dst);
        check({tag, ".valid"}, 32'(out_valid), 32'(vld));
        check({tag, ".flags"}, 32'(flags), 32'(f));
        if (vld) begin
            check({tag, ".aluop"}, 32'(ALUop), 32'(aop));
            check({tag, ".dest"}, 32'(dest_reg), 32'(dst));
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_pc = '0; in_instr = '0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        #12;
        check("reset.valid", 32'(out_valid), 32'd0);
        check("reset.pc", 32'(out_pc), 32'd0);
        check("reset.flags", 32'(flags), 32'd0);
        check("reset.target", 32'(TargetInstr), 32'd0);
        check("reset.aluop", 32'(ALUop), 32'd0);
        check("reset.dest", 32'(dest_reg), 32'd0);
        check("reset.illegal", 32'(illegal), 32'd0);
        #5 rst_n = 1'b1;

        drive(30'h10, I_ADD, 1, 0, 0);
        expect_out("add", 1, F_RW, 2'd0, 5'd3);
        check("add.rs", 32'(rs), 32'd1);
        check("add.rt", 32'(rt), 32'd2);
        check("add.pc", 32'(out_pc), 32'h10);

        drive(30'h11, I_J9, 1, 0, 0);
        expect_out("j", 1, F_J, 2'd0, 5'd0);
        check("j.target", 32'(TargetInstr), 32'd9);
        drive(30'h12, I_ADDI, 1, 0, 0);
        expect_out("j.squash", 0, 8'h00, 2'd0, 5'd0);
        drive(30'h13, I_ADDI, 1, 0, 0);
        expect_out("addi", 1, F_RW | F_AS, 2'd0, 5'd1);
        check("addi.imm", 32'(imm16), 32'd5);

        drive(30'h14, I_JAL, 1, 0, 0);
        expect_out("jal", 1, F_J | F_RW, 2'd0, 5'd31);
        drive(30'h15, 32'h0, 0, 0, 0);
        expect_out("jal.bubble", 0, 8'h00, 2'd0, 5'd0);
        drive(30'h16, I_XORI, 1, 0, 0);
        expect_out("jal.squash", 0, 8'h00, 2'd0, 5'd0);
        drive(30'h17, I_JR, 1, 0, 0);
        expect_out("jr", 1, F_JR, 2'd0, 5'd0);
        check("jr.rs", 32'(rs), 32'd31);
        drive(30'h18, I_ADD, 1, 0, 1);
        expect_out("jr.flush", 0, 8'h00, 2'd0, 5'd0);
        drive(30'h19, I_ADD, 1, 0, 0);
        expect_out("after_flush", 1, F_RW, 2'd0, 5'd3);

        drive(30'h1A, I_BNE, 1, 0, 0);
        expect_out("bne", 1, F_BR | F_INV, 2'd1, 5'd0);
        check("bne.imm", 32'(imm16), 32'd3);
        drive(30'h1B, I_XORI, 1, 0, 0);
        expect_out("xori", 1, F_RW | F_AS, 2'd2, 5'd2);

        drive(30'h20, I_LW, 1, 0, 0);
        expect_out("lw", 1, F_RW | F_MR | F_AS, 2'd0, 5'd3);
        for (int i = 0; i < 3; i++) begin
            drive(30'h21, I_SW, 1, 1, 0);
            expect_out("lw.stall", 1, F_RW | F_MR | F_AS, 2'd0, 5'd3);
            check("lw.stall.pc", 32'(out_pc), 32'h20);
        end
        drive(30'h21, I_SW, 1, 0, 1);
        expect_out("lw.flush", 0, 8'h00, 2'd0, 5'd0);
        drive(30'h22, I_SW, 1, 0, 0);
        expect_out("sw", 1, F_MW | F_AS, 2'd0, 5'd0);
        drive(30'h23, I_SLT, 1, 0, 0);
        expect_out("slt", 1, F_RW, 2'd3, 5'd3);
        drive(30'h24, I_SUB, 1, 0, 0);
        expect_out("sub", 1, F_RW, 2'd1, 5'd3);

        drive(30'h25, I_J9, 1, 0, 0);
        expect_out("j2", 1, F_J, 2'd0, 5'd0);
        drive(30'h26, I_ADD, 1, 0, 1);
        expect_out("j2.flush", 0, 8'h00, 2'd0, 5'd0);
        drive(30'h27, I_ADD, 1, 0, 0);
        expect_out("j2.cleared", 1, F_RW, 2'd0, 5'd3);

        drive(30'h28, I_BAD, 1, 0, 1);
        expect_out("bad.flush", 0, 8'h00, 2'd0, 5'd0);
        check("bad.flush.illegal", 32'(illegal), 32'd0);
        drive(30'h29, I_ADD, 1, 0, 0);
        expect_out("bad.flush.next", 1, F_RW, 2'd0, 5'd3);

        drive(30'h2A, I_J9, 1, 0, 0);
        expect_out("j3", 1, F_J, 2'd0, 5'd0);
        pulse_reset();
        drive(30'h2B, I_ADD, 1, 0, 0);
        expect_out("rst.nosquash", 1, F_RW, 2'd0, 5'd3);

`ifdef ID_ILLEGAL_TRAP_EN
        drive(30'h30, I_BAD, 1, 0, 0);
        expect_out("trap", 0, 8'h00, 2'd0, 5'd0);
        check("trap.illegal", 32'(illegal), 32'd1);
        drive(30'h31, I_ADD, 1, 0, 0);
        expect_out("halt.add", 0, 8'h00, 2'd0, 5'd0);
        drive(30'h32, I_ADD, 1, 0, 1);
        check("halt.flush.illegal", 32'(illegal), 32'd1);
        check("halt.flush.valid", 32'(out_valid), 32'd0);
        pulse_reset();
        drive(30'h33, I_ADD, 1, 0, 0);
        expect_out("halt.exit", 1, F_RW, 2'd0, 5'd3);
`else
        drive(30'h30, I_BAD, 1, 0, 0);
        expect_out("nop.op", 1, 8'h00, 2'd0, 5'd0);
        check("nop.op.illegal", 32'(illegal), 32'd0);
        drive(30'h31, 32'h0000_0000, 1, 0, 0);
        expect_out("nop.funct", 1, 8'h00, 2'd0, 5'd0);
        check("nop.funct.illegal", 32'(illegal), 32'd0);
        drive(30'h32, I_ADD, 1, 0, 0);
        expect_out("nop.next", 1, F_RW, 2'd0, 5'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
